// File: rtl/seq_chunk_adder_pkg.sv
// Shared types and helpers for the chunked sequential adder.
// Holds the controller state encoding and the counter-width calculation.
package seq_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Counter must be at least one bit wide even when a single chunk covers the word.
    function automatic int cnt_width(input int nchunk);
        int w;
        w = $clog2(nchunk);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/seq_chunk_adder_cfg_chk.sv
// Elaboration-time guard on the adder geometry.
// Stops elaboration when the word does not split into whole chunks.
module seq_chunk_adder_cfg_chk #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) ();

    if (CHUNK < 1) begin : g_chunk_too_small
        $error("seq_chunk_adder: CHUNK must be at least 1");
    end else if ((WIDTH % CHUNK) != 0) begin : g_width_not_multiple
        $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK");
    end

endmodule

// File: rtl/seq_chunk_adder_ripple.sv
// Combinational N-bit ripple adder used for one chunk per cycle.
// Also exposes the carry into the top bit so the caller can form signed overflow.
module chunk_ripple_add #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co,
    output logic         c_msb
);

    logic [N:0] c_s;

    // Bit-serial carry chain across the chunk.
    always_comb begin
        c_s    = '0;
        s      = '0;
        c_s[0] = ci;
        for (int i = 0; i < N; i++) begin
            s[i]     = a[i] ^ b[i] ^ c_s[i];
            c_s[i+1] = (a[i] & b[i]) | (a[i] & c_s[i]) | (b[i] & c_s[i]);
        end
    end

    assign co    = c_s[N];
    assign c_msb = c_s[N-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract: CHUNK bits per clock with the carry registered between chunks.
// Valid/ready on both sides; one operation in flight at a time.
module seq_chunk_adder
    import seq_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = cnt_width(NCHUNK);
    localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

    seq_chunk_adder_cfg_chk #(.WIDTH(WIDTH), .CHUNK(CHUNK)) u_cfg_chk ();

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic            carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;
    logic            out_valid_q, out_valid_d;

    logic [CHUNK-1:0] a_chunk_s;
    logic [CHUNK-1:0] b_chunk_s;
    logic [CHUNK-1:0] s_chunk_s;
    logic             co_s;
    logic             c_msb_s;

    // Select the operand chunk addressed by the counter (one-hot OR mux).
    always_comb begin
        a_chunk_s = '0;
        b_chunk_s = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            a_chunk_s |= (cnt_q == CW'(i)) ? a_q[i*CHUNK +: CHUNK] : '0;
            b_chunk_s |= (cnt_q == CW'(i)) ? b_q[i*CHUNK +: CHUNK] : '0;
        end
    end

    chunk_ripple_add #(.N(CHUNK)) u_chunk_add (
        .a     (a_chunk_s),
        .b     (b_chunk_s),
        .ci    (carry_q),
        .s     (s_chunk_s),
        .co    (co_s),
        .c_msb (c_msb_s)
    );

    // Controller next-state and datapath updates.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = Sub ? ~B : B;
                    carry_d = Cin ^ Sub;
                    cnt_d   = '0;
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                for (int i = 0; i < NCHUNK; i++) begin
                    sum_d[i*CHUNK +: CHUNK] = (cnt_q == CW'(i)) ? s_chunk_s
                                                                : sum_q[i*CHUNK +: CHUNK];
                end
                carry_d = co_s;
                if (cnt_q == LAST_CNT) begin
                    cout_d      = co_s;
                    ovf_d       = c_msb_s ^ co_s;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign Sum       = sum_q;
    assign Cout      = cout_q;
    assign Ovf       = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Self-checking bench: 16/4 instance for directed scenarios, 4/1 instance for the exhaustive sweep.
module tb_seq_chunk_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic [15:0] A = 16'h0000, B = 16'h0000;
    logic        Cin = 1'b0, Sub = 1'b0;
    logic        in_ready, out_valid, Cout, Ovf;
    logic [15:0] Sum;

    logic        x_in_valid = 1'b0, x_out_ready = 1'b0;
    logic [3:0]  x_A = 4'h0, x_B = 4'h0;
    logic        x_Cin = 1'b0, x_Sub = 1'b0;
    logic        x_in_ready, x_out_valid, x_Cout, x_Ovf;
    logic [3:0]  x_Sum;

    seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Cin(Cin), .Sub(Sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .Sum(Sum), .Cout(Cout), .Ovf(Ovf)
    );

    seq_chunk_adder #(.WIDTH(4), .CHUNK(1)) dut_x (
        .clk(clk), .rst(rst), .in_valid(x_in_valid), .in_ready(x_in_ready),
        .A(x_A), .B(x_B), .Cin(x_Cin), .Sub(x_Sub),
        .out_valid(x_out_valid), .out_ready(x_out_ready),
        .Sum(x_Sum), .Cout(x_Cout), .Ovf(x_Ovf)
    );

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference for the 4-bit instance: signed overflow from operand/result signs.
    function automatic exp_t model4(input logic [3:0] a, input logic [3:0] b,
                                    input logic cin, input logic sub);
        logic [3:0] bb;
        logic [4:0] full;
        exp_t       e;
        bb     = sub ? ~b : b;
        full   = {1'b0, a} + {1'b0, bb} + {4'b0000, cin ^ sub};
        e.sum  = {12'h000, full[3:0]};
        e.cout = full[4];
        e.ovf  = (a[3] == bb[3]) && (full[3] != a[3]);
        return e;
    endfunction

    task automatic issue16(input logic [15:0] a, input logic [15:0] b,
                           input logic cin, input logic sub);
        int guard = 0;
        while (!in_ready && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL issue16_ready got in_ready=%b want 1", in_ready);
        end
        A = a; B = b; Cin = cin; Sub = sub; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait16(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic release16();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic issue4(input logic [3:0] a, input logic [3:0] b,
                          input logic cin, input logic sub);
        int guard = 0;
        while (!x_in_ready && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        x_A = a; x_B = b; x_Cin = cin; x_Sub = sub; x_in_valid = 1'b1;
        @(posedge clk); #1;
        x_in_valid = 1'b0;
    endtask

    task automatic wait4(output int lat);
        lat = 0;
        while (!x_out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        n_checks++;
        if ({out_valid, Sum, Cout, Ovf, in_ready} !== 20'h00000) begin
            n_fail++;
            $display("FAIL reset_state got ov=%b sum=%h c=%b o=%b rdy=%b want all 0",
                     out_valid, Sum, Cout, Ovf, in_ready);
        end
        n_checks++;
        if ({x_out_valid, x_Sum, x_in_ready} !== 6'b000000) begin
            n_fail++;
            $display("FAIL reset_state_x got ov=%b sum=%h rdy=%b want 0", x_out_valid, x_Sum, x_in_ready);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready got %b want 1", in_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset got rdy=%b ov=%b want rdy=1 ov=0", in_ready, out_valid);
        end
    endtask

    task automatic test_arith();
        logic [15:0] va [7] = '{16'h0003, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h1234, 16'h00FF};
        logic [15:0] vb [7] = '{16'h0005, 16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h0234, 16'h0F00};
        logic        vc [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic        vs [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_t        ve [7] = '{{16'h0008, 1'b0, 1'b0}, {16'h0000, 1'b1, 1'b0},
                                {16'h8000, 1'b0, 1'b1}, {16'hFFFE, 1'b0, 1'b0},
                                {16'h7FFF, 1'b1, 1'b1}, {16'h0FFF, 1'b1, 1'b0},
                                {16'h1000, 1'b0, 1'b0}};
        exp_t e;
        int   lat;
        for (int i = 0; i < 7; i++) begin
            sb.push_back(ve[i]);
            issue16(va[i], vb[i], vc[i], vs[i]);
            wait16(lat);
            e = sb.pop_front();
            n_checks++;
            if (lat != 4) begin
                n_fail++;
                $display("FAIL arith_latency[%0d] got %0d want 4", i, lat);
            end
            n_checks++;
            if ({Sum, Cout, Ovf} !== {e.sum, e.cout, e.ovf}) begin
                n_fail++;
                $display("FAIL arith_result[%0d] got sum=%h c=%b o=%b want sum=%h c=%b o=%b",
                         i, Sum, Cout, Ovf, e.sum, e.cout, e.ovf);
            end
            release16();
            n_checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL arith_handshake[%0d] got ov=%b rdy=%b want ov=0 rdy=1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   lat;
        int   bad = 0;
        sb.push_back('{16'h3333, 1'b0, 1'b0});
        issue16(16'h1111, 16'h2222, 1'b0, 1'b0);
        wait16(lat);
        e = sb.pop_front();
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin
                A = 16'hAAAA; B = 16'h5555; in_valid = 1'b1;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                {Sum, Cout, Ovf} !== {e.sum, e.cout, e.ovf}) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL backpressure_hold got %0d unstable cycles (sum=%h ov=%b rdy=%b) want 0",
                     bad, Sum, out_valid, in_ready);
        end
        release16();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_release got ov=%b rdy=%b want ov=0 rdy=1", out_valid, in_ready);
        end
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL backpressure_ignored_input got %0d valid cycles want 0", bad);
        end
    endtask

    task automatic test_abort();
        int bad = 0;
        issue16(16'h0003, 16'h0005, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || Sum !== 16'h0000 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_reset got ov=%b sum=%h rdy=%b want ov=0 sum=0000 rdy=1",
                     out_valid, Sum, in_ready);
        end
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) bad++;
        end
        rst = 1'b1; in_valid = 1'b1; A = 16'h0001; B = 16'h0001; Cin = 1'b0; Sub = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_blocks_ready got %b want 0", in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_no_output got %0d valid cycles rdy=%b want 0 and rdy=1", bad, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   seen = 0;
        int   last_c = -1;
        int   bad_gap = 0;
        out_ready = 1'b1;
        A = 16'h0100; B = 16'h0200; Cin = 1'b0; Sub = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 18; c++) begin
            if (in_ready) sb.push_back('{16'h0300, 1'b0, 1'b0});
            @(posedge clk); #1;
            if (out_valid) begin
                e = sb.pop_front();
                seen++;
                n_checks++;
                if (Sum !== e.sum || Cout !== e.cout || Ovf !== e.ovf) begin
                    n_fail++;
                    $display("FAIL b2b_result got sum=%h want %h", Sum, e.sum);
                end
                if (last_c >= 0 && c - last_c != 6) bad_gap++;
                last_c = c;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        n_checks++;
        if (seen != 3 || bad_gap != 0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_throughput got %0d results, %0d bad gaps, %0d pending want 3,0,0",
                     seen, bad_gap, sb.size());
        end
    endtask

    task automatic test_exhaustive();
        exp_t e;
        int   lat;
        int   printed = 0;
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    for (int c = 0; c < 2; c++) begin
                        sb.push_back(model4(4'(a), 4'(b), 1'(c), 1'(s)));
                        issue4(4'(a), 4'(b), 1'(c), 1'(s));
                        wait4(lat);
                        e = sb.pop_front();
                        n_checks++;
                        if (lat != 4 || {x_Sum, x_Cout, x_Ovf} !== {e.sum[3:0], e.cout, e.ovf}) begin
                            n_fail++;
                            if (printed < 20) begin
                                printed++;
                                $display("FAIL exhaustive a=%0d b=%0d cin=%0d sub=%0d got sum=%h c=%b o=%b lat=%0d want sum=%h c=%b o=%b lat=4",
                                         a, b, c, s, x_Sum, x_Cout, x_Ovf, lat, e.sum[3:0], e.cout, e.ovf);
                            end
                        end
                        x_out_ready = 1'b1;
                        @(posedge clk); #1;
                        x_out_ready = 1'b0;
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_backpressure();
        test_abort();
        test_back_to_back();
        test_exhaustive();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
